fft_output_serializer: RTL and testbench

Back-end of the CORDIC FFT pipeline: accepts the final stage's butterfly output pairs, stores each 1024-point frame in a ping-pong complex RAM at bit-reversed addresses, and streams the frame out one complex bin per cycle in natural frequency order. The output uses a valid/ready handshake. It is the reader counterpart to the stage writers: stages pack pairs into banks, and this block unpacks them into a serial, backpressured stream for the host or DMA.

---
 rtl/fft_pkg.sv | 20 ++
 rtl/fft_output_serializer_if.sv | 29 ++
 rtl/dual_port_ram.sv | 22 ++
 rtl/fft_out_skid.sv | 51 +++++
 rtl/fft_output_serializer.sv | 174 +++++++++++++++++
 tb/tb_fft_output_serializer.sv | 357 +++++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/fft_pkg.sv
// Shared constants, types and helpers for the FFT output serializer slice.
package fft_pkg;
    localparam int N      = 1024;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] { RD_IDLE, RD_RUN, RD_DRAIN } rd_state_e;

    typedef struct packed {
        logic signed [DATA_W-1:0] re;
        logic signed [DATA_W-1:0] im;
        logic [ADDR_W-1:0]        idx;
    } bin_t;

    function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] x);
        logic [ADDR_W-1:0] r;
        for (int i = 0; i < ADDR_W; i++) r[i] = x[ADDR_W-1-i];
        return r;
    endfunction
endpackage

// File: rtl/fft_output_serializer_if.sv
// Butterfly-pair input and serial bin output bundle of the FFT output serializer.
interface fft_output_serializer_if;
    import fft_pkg::*;

    logic                     i_valid_in;
    logic signed [DATA_W-1:0] i_data_a_real;
    logic signed [DATA_W-1:0] i_data_a_imag;
    logic signed [DATA_W-1:0] i_data_b_real;
    logic signed [DATA_W-1:0] i_data_b_imag;
    logic                     i_ready;
    logic                     o_valid;
    logic signed [DATA_W-1:0] o_data_real;
    logic signed [DATA_W-1:0] o_data_imag;
    logic [ADDR_W-1:0]        o_index;
    logic                     o_sof;
    logic                     o_eof;
    logic                     o_in_ready;
    logic                     o_overflow;

    modport slave (
        input  i_valid_in, i_data_a_real, i_data_a_imag, i_data_b_real, i_data_b_imag, i_ready,
        output o_valid, o_data_real, o_data_imag, o_index, o_sof, o_eof, o_in_ready, o_overflow
    );

    modport master (
        output i_valid_in, i_data_a_real, i_data_a_imag, i_data_b_real, i_data_b_imag, i_ready,
        input  o_valid, o_data_real, o_data_imag, o_index, o_sof, o_eof, o_in_ready, o_overflow
    );
endinterface

// File: rtl/dual_port_ram.sv
// Synchronous RAM: port A read/write with 1-cycle read latency, port B write-only.
module dual_port_ram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_we_a,
    input  logic [ADDR_W-1:0] i_addr_a,
    input  logic [DATA_W-1:0] i_din_a,
    output logic [DATA_W-1:0] o_dout_a,
    input  logic              i_we_b,
    input  logic [ADDR_W-1:0] i_addr_b,
    input  logic [DATA_W-1:0] i_din_b
);
    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge i_clk) begin
        if (i_we_a) mem_q[i_addr_a] <= i_din_a;
        if (i_we_b) mem_q[i_addr_b] <= i_din_b;
        o_dout_a <= mem_q[i_addr_a];
    end
endmodule

// File: rtl/fft_out_skid.sv
// Two-entry valid/ready skid buffer for output bins; reports occupancy so the
// reader can throttle RAM reads.
module fft_out_skid
    import fft_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_push,
    input  bin_t       i_bin,
    input  logic       i_ready,
    output logic       o_valid,
    output bin_t       o_bin,
    output logic [1:0] o_occ
);
    bin_t [1:0] ent_q, ent_d;
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] cnt_q, cnt_d;
    logic       pop;

    always_comb begin
        ent_d    = ent_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        pop      = (cnt_q != 2'd0) & i_ready;
        if (i_push) begin
            ent_d[wr_ptr_q] = i_bin;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) rd_ptr_d = ~rd_ptr_q;
        cnt_d = cnt_q + {1'b0, i_push} - {1'b0, pop};
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            ent_q    <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            ent_q    <= ent_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign o_valid = (cnt_q != 2'd0);
    assign o_bin   = ent_q[rd_ptr_q];
    assign o_occ   = cnt_q;
endmodule

// File: rtl/fft_output_serializer.sv
// Stores bit-reversed butterfly pairs into a ping-pong complex RAM and streams
// each frame out in natural bin order over a valid/ready handshake.
module fft_output_serializer
    import fft_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_reset,
    fft_output_serializer_if.slave bus
);
    logic [ADDR_W-2:0] wr_cnt_q, wr_cnt_d;
    logic              wr_bank_q, wr_bank_d;
    logic              discard_q, discard_d;
    logic              overflow_q, overflow_d;
    logic [1:0]        full_q, full_d;
    logic              frame_start, drop_now, wr_en;
    logic [ADDR_W-1:0] wr_addr_a, wr_addr_b;

    rd_state_e         state_q, state_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              rd_bank_q, rd_bank_d;
    logic              rd_vld_p1_q, rd_vld_p1_d;
    logic [ADDR_W-1:0] rd_idx_p1_q, rd_idx_p1_d;
    logic              rd_done, room, pop;
    logic [1:0]        load;

    logic [DATA_W-1:0] dout_re [2];
    logic [DATA_W-1:0] dout_im [2];
    bin_t              sk_in, sk_out;
    logic              sk_valid;
    logic [1:0]        sk_occ;

    // Admission is decided once per frame at pair 0; later pairs follow that decision.
    always_comb begin
        frame_start = (wr_cnt_q == '0);
        drop_now    = frame_start ? full_q[wr_bank_q] : discard_q;
        wr_en       = bus.i_valid_in & ~drop_now;
        wr_addr_a   = bitrev({wr_cnt_q, 1'b0});
        wr_addr_b   = bitrev({wr_cnt_q, 1'b1});

        wr_cnt_d   = wr_cnt_q;
        wr_bank_d  = wr_bank_q;
        discard_d  = discard_q;
        overflow_d = overflow_q;
        full_d     = full_q;
        if (rd_done) full_d[rd_bank_q] = 1'b0;
        if (bus.i_valid_in) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
            if (frame_start) begin
                discard_d = full_q[wr_bank_q];
                if (full_q[wr_bank_q]) overflow_d = 1'b1;
            end
            if ((&wr_cnt_q) && !drop_now) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
            end
        end
    end

    // Gate on occupancy after this cycle's pop so a free-flowing stream issues every cycle.
    always_comb begin
        pop  = sk_valid & bus.i_ready;
        load = sk_occ - {1'b0, pop} + {1'b0, rd_vld_p1_q};
        room = (load < 2'd2);

        state_d     = state_q;
        rd_addr_d   = rd_addr_q;
        rd_bank_d   = rd_bank_q;
        rd_done     = 1'b0;
        rd_vld_p1_d = 1'b0;
        rd_idx_p1_d = rd_addr_q;
        case (state_q)
            RD_IDLE: begin
                if (full_q[rd_bank_q]) state_d = RD_RUN;
            end
            RD_RUN: begin
                if (room) begin
                    rd_vld_p1_d = 1'b1;
                    rd_addr_d   = rd_addr_q + 1'b1;
                    if (&rd_addr_q) state_d = RD_DRAIN;
                end
            end
            RD_DRAIN: begin
                if (pop && (&sk_out.idx)) begin
                    rd_done   = 1'b1;
                    rd_bank_d = ~rd_bank_q;
                    state_d   = RD_IDLE;
                end
            end
            default: state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            wr_cnt_q    <= '0;
            wr_bank_q   <= 1'b0;
            discard_q   <= 1'b0;
            overflow_q  <= 1'b0;
            full_q      <= 2'b00;
            state_q     <= RD_IDLE;
            rd_addr_q   <= '0;
            rd_bank_q   <= 1'b0;
            rd_vld_p1_q <= 1'b0;
            rd_idx_p1_q <= '0;
        end else begin
            wr_cnt_q    <= wr_cnt_d;
            wr_bank_q   <= wr_bank_d;
            discard_q   <= discard_d;
            overflow_q  <= overflow_d;
            full_q      <= full_d;
            state_q     <= state_d;
            rd_addr_q   <= rd_addr_d;
            rd_bank_q   <= rd_bank_d;
            rd_vld_p1_q <= rd_vld_p1_d;
            rd_idx_p1_q <= rd_idx_p1_d;
        end
    end

    // Port A is shared: the write bank uses it for element A, the full bank for reads.
    for (genvar b = 0; b < 2; b++) begin : g_bank
        logic              we;
        logic [ADDR_W-1:0] addr_a;
        assign we     = wr_en & (wr_bank_q == 1'(b));
        assign addr_a = we ? wr_addr_a : rd_addr_q;

        dual_port_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram_re (
            .i_clk    (i_clk),
            .i_we_a   (we),
            .i_addr_a (addr_a),
            .i_din_a  (bus.i_data_a_real),
            .o_dout_a (dout_re[b]),
            .i_we_b   (we),
            .i_addr_b (wr_addr_b),
            .i_din_b  (bus.i_data_b_real)
        );

        dual_port_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram_im (
            .i_clk    (i_clk),
            .i_we_a   (we),
            .i_addr_a (addr_a),
            .i_din_a  (bus.i_data_a_imag),
            .o_dout_a (dout_im[b]),
            .i_we_b   (we),
            .i_addr_b (wr_addr_b),
            .i_din_b  (bus.i_data_b_imag)
        );
    end

    always_comb begin
        sk_in.re  = dout_re[rd_bank_q];
        sk_in.im  = dout_im[rd_bank_q];
        sk_in.idx = rd_idx_p1_q;
    end

    fft_out_skid u_skid (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (rd_vld_p1_q),
        .i_bin   (sk_in),
        .i_ready (bus.i_ready),
        .o_valid (sk_valid),
        .o_bin   (sk_out),
        .o_occ   (sk_occ)
    );

    assign bus.o_valid     = sk_valid;
    assign bus.o_data_real = sk_out.re;
    assign bus.o_data_imag = sk_out.im;
    assign bus.o_index     = sk_out.idx;
    assign bus.o_sof       = sk_valid & (sk_out.idx == '0);
    assign bus.o_eof       = sk_valid & (&sk_out.idx);
    assign bus.o_in_ready  = ~full_q[wr_bank_q] | (~frame_start & ~discard_q);
    assign bus.o_overflow  = overflow_q;
endmodule

// File: tb/tb_fft_output_serializer.sv
// Randomized bench for fft_output_serializer against a natural-order frame model.
module tb_fft_output_serializer;
    import fft_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fft_output_serializer_if bus();

    fft_output_serializer dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_cnt  = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Frame f as the sample sequence fed in pair order: pair k = (s[2k], s[2k+1]).
    logic signed [DATA_W-1:0] src_re [4][N];
    logic signed [DATA_W-1:0] src_im [4][N];

    logic signed [DATA_W-1:0] rx_re  [2*N];
    logic signed [DATA_W-1:0] rx_im  [2*N];
    logic [ADDR_W-1:0]        rx_idx [2*N];
    logic                     rx_sof [2*N];
    logic                     rx_eof [2*N];
    int rx_cnt, stall_changes, first_vld_cyc, last_pair_cyc;

    function automatic int bitrev_ref(input int x);
        int r = 0;
        for (int i = 0; i < ADDR_W; i++)
            if ((x >> i) % 2 == 1) r = r + (1 << (ADDR_W - 1 - i));
        return r;
    endfunction

    task automatic fill_random(input int f);
        for (int m = 0; m < N; m++) begin
            src_re[f][m] = $urandom;
            src_im[f][m] = $urandom;
        end
    endtask

    task automatic apply_reset();
        bus.i_valid_in    = 1'b0;
        bus.i_data_a_real = '0;
        bus.i_data_a_imag = '0;
        bus.i_data_b_real = '0;
        bus.i_data_b_imag = '0;
        bus.i_ready       = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Entered and left at 1 time unit after a rising edge.
    task automatic drive_frame(input int f, input int gap);
        for (int k = 0; k < N/2; k++) begin
            bus.i_valid_in    = 1'b1;
            bus.i_data_a_real = src_re[f][2*k];
            bus.i_data_a_imag = src_im[f][2*k];
            bus.i_data_b_real = src_re[f][2*k+1];
            bus.i_data_b_imag = src_im[f][2*k+1];
            last_pair_cyc = cyc_cnt;
            @(posedge clk);
            #1 bus.i_valid_in = 1'b0;
            for (int g = 0; g < gap; g++) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    // Records handshaken bins and counts output changes during stalls.
    task automatic capture(input int nbins, input int rdy_pct, input int budget);
        int cyc = 0;
        logic prev_stall = 1'b0;
        logic [76:0] held = '0;
        logic [76:0] now;
        rx_cnt = 0;
        stall_changes = 0;
        first_vld_cyc = -1;
        while (rx_cnt < nbins && cyc < budget) begin
            @(posedge clk);
            #1 bus.i_ready = ($urandom_range(99) < rdy_pct);
            @(negedge clk);
            cyc++;
            now = {bus.o_valid, bus.o_data_real, bus.o_data_imag, bus.o_index, bus.o_sof, bus.o_eof};
            if (prev_stall && now !== held) stall_changes++;
            if (bus.o_valid === 1'b1 && first_vld_cyc < 0) first_vld_cyc = cyc_cnt;
            if (bus.o_valid === 1'b1 && bus.i_ready === 1'b1) begin
                rx_re[rx_cnt]  = bus.o_data_real;
                rx_im[rx_cnt]  = bus.o_data_imag;
                rx_idx[rx_cnt] = bus.o_index;
                rx_sof[rx_cnt] = bus.o_sof;
                rx_eof[rx_cnt] = bus.o_eof;
                rx_cnt++;
            end
            prev_stall = (bus.o_valid === 1'b1) && (bus.i_ready === 1'b0);
            held = now;
        end
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if ({bus.o_valid, bus.o_data_real, bus.o_data_imag, bus.o_index, bus.o_sof, bus.o_eof, bus.o_overflow} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b re=%h im=%h idx=%0d sof=%b eof=%b ovf=%b, expected all 0",
                     bus.o_valid, bus.o_data_real, bus.o_data_imag, bus.o_index, bus.o_sof, bus.o_eof, bus.o_overflow);
        end
        n_checks++;
        if (bus.o_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b expected 1", bus.o_in_ready);
        end
    endtask

    task automatic test_impulse();
        logic [ADDR_W+1:0] e, a;
        apply_reset();
        for (int m = 0; m < N; m++) begin src_re[0][m] = '0; src_im[0][m] = '0; end
        src_re[0][0] = 1000;
        fork
            drive_frame(0, 0);
            capture(N, 100, 3000);
        join
        n_checks++;
        if (first_vld_cyc - last_pair_cyc !== 4) begin
            n_fail++;
            $display("FAIL impulse_latency: got %0d cycles expected 4", first_vld_cyc - last_pair_cyc);
        end
        n_checks++;
        if (rx_cnt !== N) begin
            n_fail++;
            $display("FAIL impulse_count: got %0d bins expected %0d", rx_cnt, N);
        end
        n_checks++;
        if ({rx_re[0], rx_im[0], rx_sof[0]} !== {32'sd1000, 32'sd0, 1'b1}) begin
            n_fail++;
            $display("FAIL impulse_bin0: got re=%0d im=%0d sof=%b expected 1000 0 1", rx_re[0], rx_im[0], rx_sof[0]);
        end
        for (int j = 1; j < N; j++) begin
            e = {ADDR_W'(j), 1'b0, 1'(j == N-1)};
            a = {rx_idx[j], rx_sof[j], rx_eof[j]};
            n_checks++;
            if ({rx_re[j], rx_im[j]} !== 64'd0 || a !== e) begin
                n_fail++;
                $display("FAIL impulse_bin %0d: got re=%0d im=%0d idx/sof/eof=%h expected 0 0 %h",
                         j, rx_re[j], rx_im[j], a, e);
            end
        end
    endtask

    task automatic test_reorder();
        apply_reset();
        for (int m = 0; m < N; m++) begin src_re[0][m] = m; src_im[0][m] = '0; end
        fork
            drive_frame(0, 0);
            capture(N, 100, 3000);
        join
        n_checks++;
        if ({rx_re[1], rx_re[2], rx_re[1023]} !== {32'sd512, 32'sd256, 32'sd1023}) begin
            n_fail++;
            $display("FAIL reorder_spot: got bin1=%0d bin2=%0d bin1023=%0d expected 512 256 1023",
                     rx_re[1], rx_re[2], rx_re[1023]);
        end
        for (int j = 0; j < N; j++) begin
            n_checks++;
            if (rx_re[j] !== DATA_W'(bitrev_ref(j)) || rx_idx[j] !== ADDR_W'(j)) begin
                n_fail++;
                $display("FAIL reorder_bin %0d: got re=%0d idx=%0d expected re=%0d idx=%0d",
                         j, rx_re[j], rx_idx[j], bitrev_ref(j), j);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [ADDR_W+1:0] e, a;
        apply_reset();
        fill_random(0);
        fork
            drive_frame(0, 0);
            capture(N, 30, 12000);
        join
        n_checks++;
        if (rx_cnt !== N) begin
            n_fail++;
            $display("FAIL bp_count: got %0d bins expected %0d", rx_cnt, N);
        end
        n_checks++;
        if (stall_changes !== 0) begin
            n_fail++;
            $display("FAIL bp_stable: got %0d output changes while stalled expected 0", stall_changes);
        end
        for (int j = 0; j < N; j++) begin
            e = {ADDR_W'(j), 1'(j == 0), 1'(j == N-1)};
            a = {rx_idx[j], rx_sof[j], rx_eof[j]};
            n_checks++;
            if ({rx_re[j], rx_im[j]} !== {src_re[0][bitrev_ref(j)], src_im[0][bitrev_ref(j)]} || a !== e) begin
                n_fail++;
                $display("FAIL bp_bin %0d: got %h/%h %h expected %h/%h %h", j, rx_re[j], rx_im[j], a,
                         src_re[0][bitrev_ref(j)], src_im[0][bitrev_ref(j)], e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [ADDR_W+1:0] e, a;
        int f, b;
        apply_reset();
        fill_random(0);
        fill_random(1);
        fork
            begin drive_frame(0, 1); drive_frame(1, 1); end
            capture(2*N, 100, 8000);
        join
        n_checks++;
        if (rx_cnt !== 2*N) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d bins expected %0d", rx_cnt, 2*N);
        end
        n_checks++;
        if (bus.o_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_overflow: got %b expected 0", bus.o_overflow);
        end
        for (int j = 0; j < 2*N; j++) begin
            f = j / N;
            b = j % N;
            e = {ADDR_W'(b), 1'(b == 0), 1'(b == N-1)};
            a = {rx_idx[j], rx_sof[j], rx_eof[j]};
            n_checks++;
            if ({rx_re[j], rx_im[j]} !== {src_re[f][bitrev_ref(b)], src_im[f][bitrev_ref(b)]} || a !== e) begin
                n_fail++;
                $display("FAIL b2b_bin %0d: got %h/%h %h expected %h/%h %h", j, rx_re[j], rx_im[j], a,
                         src_re[f][bitrev_ref(b)], src_im[f][bitrev_ref(b)], e);
            end
        end
    endtask

    task automatic test_overflow();
        logic [ADDR_W+1:0] e, a;
        int f, b;
        apply_reset();
        for (int i = 0; i < 3; i++) fill_random(i);
        bus.i_ready = 1'b0;
        drive_frame(0, 0);
        drive_frame(1, 0);
        drive_frame(2, 0);
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if ({bus.o_overflow, bus.o_in_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL ovf_flags: got overflow=%b in_ready=%b expected 1 0", bus.o_overflow, bus.o_in_ready);
        end
        n_checks++;
        if ({bus.o_valid, bus.o_index, bus.o_sof} !== {1'b1, ADDR_W'(0), 1'b1}) begin
            n_fail++;
            $display("FAIL ovf_held: got v=%b idx=%0d sof=%b expected 1 0 1", bus.o_valid, bus.o_index, bus.o_sof);
        end
        capture(2*N, 100, 6000);
        n_checks++;
        if (rx_cnt !== 2*N) begin
            n_fail++;
            $display("FAIL ovf_count: got %0d bins expected %0d", rx_cnt, 2*N);
        end
        for (int j = 0; j < 2*N; j++) begin
            f = j / N;
            b = j % N;
            e = {ADDR_W'(b), 1'(b == 0), 1'(b == N-1)};
            a = {rx_idx[j], rx_sof[j], rx_eof[j]};
            n_checks++;
            if ({rx_re[j], rx_im[j]} !== {src_re[f][bitrev_ref(b)], src_im[f][bitrev_ref(b)]} || a !== e) begin
                n_fail++;
                $display("FAIL ovf_bin %0d: got %h/%h %h expected %h/%h %h", j, rx_re[j], rx_im[j], a,
                         src_re[f][bitrev_ref(b)], src_im[f][bitrev_ref(b)], e);
            end
        end
        repeat (20) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({bus.o_valid, bus.o_overflow} !== 2'b01) begin
            n_fail++;
            $display("FAIL ovf_no_third: got valid=%b overflow=%b expected 0 1", bus.o_valid, bus.o_overflow);
        end
    endtask

    task automatic test_reset_mid_stream();
        logic [ADDR_W+1:0] e, a;
        int cyc = 0;
        apply_reset();
        fill_random(0);
        fill_random(1);
        bus.i_ready = 1'b1;
        drive_frame(0, 0);
        @(negedge clk);
        while (!(bus.o_valid === 1'b1 && bus.o_index === ADDR_W'(300)) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (cyc >= 3000) begin
            n_fail++;
            $display("FAIL mid_reach_300: got timeout after %0d cycles, expected bin 300", cyc);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.o_valid, bus.o_overflow, bus.o_in_ready} !== 3'b001) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got valid=%b overflow=%b in_ready=%b expected 0 0 1",
                     bus.o_valid, bus.o_overflow, bus.o_in_ready);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        fork
            drive_frame(1, 0);
            capture(N, 100, 3000);
        join
        n_checks++;
        if (rx_cnt !== N) begin
            n_fail++;
            $display("FAIL mid_count: got %0d bins expected %0d", rx_cnt, N);
        end
        for (int j = 0; j < N; j++) begin
            e = {ADDR_W'(j), 1'(j == 0), 1'(j == N-1)};
            a = {rx_idx[j], rx_sof[j], rx_eof[j]};
            n_checks++;
            if ({rx_re[j], rx_im[j]} !== {src_re[1][bitrev_ref(j)], src_im[1][bitrev_ref(j)]} || a !== e) begin
                n_fail++;
                $display("FAIL mid_bin %0d: got %h/%h %h expected %h/%h %h", j, rx_re[j], rx_im[j], a,
                         src_re[1][bitrev_ref(j)], src_im[1][bitrev_ref(j)], e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_reorder();
        test_backpressure();
        test_back_to_back();
        test_overflow();
        test_reset_mid_stream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
